// File: rtl/mem_request_queue_pkg.sv
// Shared types and default sizes for the memory request path (parser -> queue -> DRAM scheduler).
package global_defs;

    localparam int ADDRESS_WIDTH       = 36;
    localparam int QUEUE_DEPTH_DEFAULT = 16;
    localparam int AGE_WIDTH_DEFAULT   = 16;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RMW   = 2'd3
    } parsed_op_t;

    typedef struct packed {
        parsed_op_t               op;
        logic [ADDRESS_WIDTH-1:0] addr;
    } queue_entry_t;

endpackage

// File: rtl/mem_request_queue_if.sv
// Request-in / head-out bundle of the memory request queue; the queue is the slave side.
interface mem_request_queue_if
    import global_defs::*;
#(
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT,
    parameter int AGE_WIDTH   = AGE_WIDTH_DEFAULT
);
    parsed_op_t                         in_op;
    logic [ADDRESS_WIDTH-1:0]           in_addr;
    logic                               full;
    logic                               overflow;
    logic                               out_valid;
    parsed_op_t                         out_op;
    logic [ADDRESS_WIDTH-1:0]           out_addr;
    logic                               out_ready;
    logic [$clog2(QUEUE_DEPTH+1)-1:0]   occupancy;
    logic [AGE_WIDTH-1:0]               head_age;

    modport slave (
        input  in_op, in_addr, out_ready,
        output full, overflow, out_valid, out_op, out_addr, occupancy, head_age
    );

    modport master (
        output in_op, in_addr, out_ready,
        input  full, overflow, out_valid, out_op, out_addr, occupancy, head_age
    );
endinterface

// File: rtl/mem_request_queue_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (r_count != '1) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_request_queue.sv
// Circular request queue between trace parser and DRAM scheduler, with sticky overflow.
// Define MEM_QUEUE_AGE_EN to build per-entry age counters driving head_age.
module mem_request_queue
    import global_defs::*;
#(
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT,
    parameter int AGE_WIDTH   = AGE_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_request_queue_if.slave bus
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int OCC_W = $clog2(QUEUE_DEPTH + 1);

    queue_entry_t     r_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [OCC_W-1:0] r_occ;
    logic             r_overflow;

    logic         w_full;
    logic         w_empty;
    logic         w_req;
    logic         w_enq;
    logic         w_deq;
    queue_entry_t w_head;

    // full comes from registered occupancy only, so a same-cycle dequeue never frees a slot early
    assign w_full  = (r_occ == OCC_W'(QUEUE_DEPTH));
    assign w_empty = (r_occ == '0);
    assign w_req   = (bus.in_op != NOP);
    assign w_enq   = w_req && !w_full;
    assign w_deq   = !w_empty && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_occ      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_deq) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_enq && !w_deq) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (!w_enq && w_deq) begin
                r_occ <= r_occ - OCC_W'(1);
            end
            if (w_req && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Entry storage carries no reset; validity is tracked purely by occupancy.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail] <= '{op: bus.in_op, addr: bus.in_addr};
        end
    end

    assign w_head        = r_mem[r_head];
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.occupancy = r_occ;
    assign bus.out_valid = !w_empty;
    assign bus.out_op    = w_empty ? NOP : w_head.op;
    assign bus.out_addr  = w_empty ? '0  : w_head.addr;

`ifdef MEM_QUEUE_AGE_EN
    logic [AGE_WIDTH-1:0] w_age [QUEUE_DEPTH];

    // Idle slots keep counting, but their value is never observed before the next enqueue clears it.
    for (genvar g = 0; g < QUEUE_DEPTH; g++) begin : g_age
        sat_counter #(
            .WIDTH (AGE_WIDTH)
        ) u_age (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_clear (w_enq && (r_tail == PTR_W'(g))),
            .o_count (w_age[g])
        );
    end

    assign bus.head_age = w_empty ? '0 : w_age[r_head];
`else
    assign bus.head_age = '0;
`endif

endmodule

// File: tb/tb_mem_request_queue.sv
// Randomised bench for mem_request_queue against a queue-based reference model.
module tb_mem_request_queue;
    import global_defs::*;

    localparam int DEPTH = 16;
    localparam int AGE_W = 4;
    localparam int AGE_MAX = (1 << AGE_W) - 1;

    typedef struct {
        parsed_op_t               op;
        logic [ADDRESS_WIDTH-1:0] addr;
        int                       enq_cyc;
    } model_entry_t;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    model_entry_t m_q[$];
    logic         m_ovf;
    int           m_cyc;

    mem_request_queue_if #(.QUEUE_DEPTH(DEPTH), .AGE_WIDTH(AGE_W)) bus ();

    mem_request_queue #(
        .QUEUE_DEPTH (DEPTH),
        .AGE_WIDTH   (AGE_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int exp_age();
`ifdef MEM_QUEUE_AGE_EN
        int a;
        if (m_q.size() == 0) return 0;
        a = m_cyc - m_q[0].enq_cyc;
        return (a > AGE_MAX) ? AGE_MAX : a;
`else
        return 0;
`endif
    endfunction

    task automatic check_all(input string tag);
        bit empty;
        empty = (m_q.size() == 0);
        chk({tag, ".valid"},    64'(bus.out_valid), 64'(!empty));
        chk({tag, ".occ"},      64'(bus.occupancy), 64'(m_q.size()));
        chk({tag, ".full"},     64'(bus.full),      64'(m_q.size() == DEPTH));
        chk({tag, ".overflow"}, 64'(bus.overflow),  64'(m_ovf));
        chk({tag, ".op"},       64'(bus.out_op),    empty ? 64'(NOP) : 64'(m_q[0].op));
        chk({tag, ".addr"},     64'(bus.out_addr),  empty ? 64'd0 : 64'(m_q[0].addr));
        chk({tag, ".age"},      64'(bus.head_age),  64'(exp_age()));
    endtask

    // Apply one cycle of inputs, advance the model by the queue rules, then compare.
    task automatic step(input string tag, input parsed_op_t op, input logic [ADDRESS_WIDTH-1:0] addr,
                        input logic rdy);
        int  sz;
        bit  deq;
        bit  enq;
        bus.in_op     = op;
        bus.in_addr   = addr;
        bus.out_ready = rdy;
        @(posedge clk);
        sz  = m_q.size();
        deq = (sz != 0) && rdy;
        enq = (op != NOP) && (sz < DEPTH);
        m_cyc++;
        if (op != NOP && sz == DEPTH) m_ovf = 1'b1;
        if (deq) void'(m_q.pop_front());
        if (enq) m_q.push_back('{op: op, addr: addr, enq_cyc: m_cyc});
        #1;
        check_all(tag);
    endtask

    function automatic logic [ADDRESS_WIDTH-1:0] rnd_addr();
        return ADDRESS_WIDTH'({$urandom(), $urandom()});
    endfunction

    function automatic parsed_op_t rnd_op();
        return parsed_op_t'($urandom_range(1, 3));
    endfunction

    initial begin
        n_total = 0;
        n_bad   = 0;
        m_ovf   = 1'b0;
        m_cyc   = 0;
        bus.in_op     = NOP;
        bus.in_addr   = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // first request right after reset release
        step("first", READ, 36'h1F000_0000, 1'b0);
        chk("first.addr_const", 64'(bus.out_addr), 64'h1F000_0000);
        chk("first.occ_const",  64'(bus.occupancy), 64'd1);

        // hold the head to watch it age (and saturate when ages are built)
        for (int i = 0; i < 10; i++) step("age10", NOP, '0, 1'b0);
`ifdef MEM_QUEUE_AGE_EN
        chk("age10.const", 64'(bus.head_age), 64'd10);
`endif
        for (int i = 0; i < 10; i++) step("age20", NOP, '0, 1'b0);
`ifdef MEM_QUEUE_AGE_EN
        chk("age20.sat", 64'(bus.head_age), 64'(AGE_MAX));
`endif
        step("drain", NOP, '0, 1'b1);

        // fill to full, then overflow
        for (int i = 0; i < DEPTH; i++) step("fill", rnd_op(), rnd_addr(), 1'b0);
        chk("fill.full", 64'(bus.full), 64'd1);
        step("ovf", WRITE, rnd_addr(), 1'b0);
        chk("ovf.flag", 64'(bus.overflow), 64'd1);
        chk("ovf.occ",  64'(bus.occupancy), 64'(DEPTH));

        // enqueue while full is rejected even with a concurrent dequeue
        step("fulldeq", READ, rnd_addr(), 1'b1);
        chk("fulldeq.occ", 64'(bus.occupancy), 64'(DEPTH - 1));

        // drain to 5 entries, then reset in the middle of a cycle
        for (int i = 0; i < DEPTH - 6; i++) step("down", NOP, '0, 1'b1);
        chk("down.occ", 64'(bus.occupancy), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        m_q.delete();
        m_ovf = 1'b0;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // steady one-in one-out across several pointer wraps
        step("steady0", rnd_op(), rnd_addr(), 1'b0);
        for (int i = 0; i < 40; i++) begin
            step("steady", rnd_op(), rnd_addr(), 1'b1);
            chk("steady.occ1", 64'(bus.occupancy), 64'd1);
        end

        // random traffic, including out_ready on an empty queue and overflow bursts
        for (int i = 0; i < 400; i++) begin
            parsed_op_t op;
            logic       rdy;
            op  = ($urandom_range(0, 2) == 0) ? NOP : rnd_op();
            rdy = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 75));
            step("rand", op, rnd_addr(), rdy);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_request_queue.md
MEM_REQUEST_QUEUE -- requirements
Module: mem_request_queue

Interface
REQ-001 Parameter QUEUE_DEPTH, default 16; number of request entries; power of two, 2..64.
REQ-002 Parameter AGE_WIDTH, default 16; width of the per-entry age counter.
REQ-003 clk  input  1  clock.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_op  input  parsed_op_t  opcode from the trace parser; NOP = no request.
REQ-006 in_addr  input  ADDRESS_WIDTH  address accompanying in_op.
REQ-007 full  output  1  queue holds QUEUE_DEPTH entries.
REQ-008 overflow  output  1  sticky; a non-NOP op arrived while full.
REQ-009 out_valid  output  1  head entry is valid.
REQ-010 out_op  output  parsed_op_t  head entry opcode.
REQ-011 out_addr  output  ADDRESS_WIDTH  head entry address.
REQ-012 out_ready  input  1  consumer (DRAM scheduler) accepts the head this cycle.
REQ-013 occupancy  output  $clog2(QUEUE_DEPTH+1)  number of valid entries.
REQ-014 head_age  output  AGE_WIDTH  cycles the head entry has been queued.

Function
REQ-015 Enqueue on a clk rising edge when in_op != NOP and full == 0; write {in_op, in_addr} at the tail; tail pointer +1 modulo QUEUE_DEPTH.
REQ-016 in_op == NOP: no write, no state change.
REQ-017 in_op != NOP with full == 1: request dropped, overflow set to 1 and held until reset, queue contents unchanged.
REQ-018 full is derived from registered occupancy; an enqueue attempted while full is rejected even if a dequeue occurs in the same cycle.
REQ-019 Dequeue on a rising edge when out_valid && out_ready; head pointer +1 modulo QUEUE_DEPTH.
REQ-020 out_valid = (occupancy != 0); out_op/out_addr driven combinationally from the head entry; out_op = NOP and out_addr = 0 when empty.
REQ-021 No bypass: enqueue-to-out_valid latency is 1 cycle; an enqueue into an empty queue is not visible at the outputs in the same cycle.
REQ-022 Simultaneous enqueue and dequeue (non-empty, non-full): occupancy unchanged, both pointers advance.
REQ-023 Occupancy: +1 on enqueue only, -1 on dequeue only, unchanged otherwise; never exceeds QUEUE_DEPTH, never below 0.
REQ-024 Pointer wrap: pointer QUEUE_DEPTH-1 advances to 0.
REQ-025 out_ready with empty queue: ignored.
REQ-026 full = (occupancy == QUEUE_DEPTH).

Reset
REQ-027 rst_n low: head = tail = 0, occupancy = 0, overflow = 0, all entry ages = 0, entries marked invalid; full = 0, out_valid = 0, out_op = NOP, out_addr = 0, head_age = 0.
REQ-028 Reset mid-operation discards all queued requests; no dequeue is reported for them.
REQ-029 The first enqueue is accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro MEM_QUEUE_AGE_EN compiled in: each valid entry's age loads 0 on enqueue, increments by 1 every cycle thereafter, saturates at 2^AGE_WIDTH-1; head_age = head entry's age (0 when empty).
REQ-031 MEM_QUEUE_AGE_EN absent: no age storage is built; head_age tied to 0.

Structure
REQ-032 Package global_defs holds parsed_op_t, ADDRESS_WIDTH, QUEUE_DEPTH default, AGE_WIDTH default, and a packed struct queue_entry_t {op, addr}.
REQ-033 Sub-module sat_counter (width-parameterised saturating up-counter with synchronous load-zero) is instantiated per entry only under MEM_QUEUE_AGE_EN.

Verification
REQ-034 Reset, then enqueue READ 0x1F000_0000 at cycle 1 -> cycle 2: out_valid=1, out_op=READ, out_addr=0x1F000_0000, occupancy=1.
REQ-035 16 consecutive non-NOP ops with out_ready=0 -> full=1 after the 16th; a 17th WRITE -> dropped, overflow=1, occupancy stays 16.
REQ-036 Full queue; out_ready=1 and a new op in the same cycle -> new op dropped, occupancy 15, overflow=1.
REQ-037 Steady enqueue+dequeue every cycle for 40 cycles -> FIFO order preserved across pointer wrap, occupancy constant at 1.
REQ-038 MEM_QUEUE_AGE_EN: enqueue one op, hold out_ready=0 for 10 cycles -> head_age=10; with AGE_WIDTH=4, hold 20 cycles -> head_age=15.
REQ-039 Queue at occupancy 5, assert rst_n low mid-cycle -> all outputs immediately at reset values, overflow=0.
